// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions: header constants, beat geometry,
// inserter state encoding and a keep-to-byte-mask helper.
package eth_pkg;

    localparam logic [15:0] TPID_VLAN      = 16'h8100;
    localparam int          HEADER_BYTES   = 18;
    localparam int          BYTES_PER_BEAT = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        MERGE,
        FLUSH
    } state_t;

    // Expand a per-byte keep vector into a per-bit data mask.
    function automatic logic [63:0] keep_to_byte_mask(input logic [7:0] keep);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/eth_hdr_inserter_keep_count.sv
// tkeep helper: counts valid bytes of a contiguous keep vector and builds a
// contiguous keep mask from a byte count. Shared with the parser side.
module eth_hdr_inserter_keep_count
    import eth_pkg::*;
(
    input  logic [7:0] keep_in,
    output logic [3:0] count_out,
    input  logic [3:0] count_in,
    output logic [7:0] mask_out
);

    // Population count of the keep vector (keep is contiguous from bit 0).
    always_comb begin
        count_out = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            count_out = count_out + {3'b000, keep_in[i]};
        end
    end

    // Byte gi is kept when it lies below the requested count.
    generate
        for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_mask
            assign mask_out[gi] = (count_in > 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/eth_hdr_inserter.sv
// Prepends an 18-byte VLAN-tagged Ethernet header (DA, SA, TPID, TCI,
// EtherType) to a 64-bit payload stream. The 2-byte overhang of the header
// beyond two beats is carried forward, so every payload beat is shifted by
// two bytes; a final overflow beat is emitted when the last payload beat
// has more than six bytes.
module eth_hdr_inserter #(
    parameter int DATA_WIDTH   = 64,
    parameter int HEADER_BYTES = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hdr_valid,
    output logic                      hdr_ready,
    input  logic [47:0]               hdr_dst_mac,
    input  logic [47:0]               hdr_src_mac,
    input  logic [15:0]               hdr_vlan_tci,
    input  logic [15:0]               hdr_ethertype,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      frame_done
);

    import eth_pkg::*;

    // Header bytes left over after the two full header beats.
    localparam int CARRY_BYTES = HEADER_BYTES - 2 * BYTES_PER_BEAT;

    state_t       state_reg;
    logic [79:0]  hdr_reg;        // header bytes 8..17, network order
    logic [15:0]  carry_reg;      // carry byte 0 in [7:0]
    logic [3:0]   flush_cnt_reg;  // valid bytes of the pending overflow beat
    logic [63:0]  m_tdata_reg;
    logic [7:0]   m_tkeep_reg;
    logic         m_tlast_reg;
    logic         m_tvalid_reg;
    logic         frame_done_reg;

    logic [143:0] hdr_in_net;
    logic [63:0]  beat0_data;
    logic [63:0]  beat1_data;
    logic [63:0]  merge_raw;
    logic [3:0]   s_count;
    logic [3:0]   mask_cnt;
    logic [7:0]   out_mask;
    logic [63:0]  out_byte_mask;
    logic         out_free;

    // Header in wire order: byte 0 sits in the top byte of this vector.
    assign hdr_in_net = {hdr_dst_mac, hdr_src_mac, TPID_VLAN, hdr_vlan_tci, hdr_ethertype};

    // Reorder network-order header bytes into little-endian beat lanes.
    generate
        for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_hdr_lanes
            assign beat0_data[8*gi +: 8] = hdr_in_net[143 - 8*gi -: 8];
            assign beat1_data[8*gi +: 8] = hdr_reg[79 - 8*gi -: 8];
        end
    endgenerate

    assign merge_raw = {s_tdata[47:0], carry_reg};
    assign out_free  = !m_tvalid_reg || m_tready;

    // hdr_ready also requires a free output register so the first header
    // beat can be loaded on the handshake edge, even while the previous
    // frame's tlast beat is draining.
    assign hdr_ready = !rst && (state_reg == IDLE) && out_free;

    // Payload is accepted from HDR1 onward so the first merged beat follows
    // header beat 1 without a bubble; in HDR1 out_free means beat 1 leaves now.
    assign s_tready = ((state_reg == HDR1) || (state_reg == MERGE)) && out_free;

    eth_hdr_inserter_keep_count u_keep_count (
        .keep_in   (s_tkeep),
        .count_out (s_count),
        .count_in  (mask_cnt),
        .mask_out  (out_mask)
    );

    // Byte count of the beat to be loaded next: full, short last, or overflow.
    always_comb begin
        mask_cnt = 4'd8;
        if (state_reg == FLUSH) begin
            mask_cnt = flush_cnt_reg;
        end else if (s_tlast && (s_count <= 4'd6)) begin
            mask_cnt = s_count + 4'(CARRY_BYTES);
        end
    end

    assign out_byte_mask = keep_to_byte_mask(out_mask);

    // Framing FSM with registered output stage; the stage only reloads when free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hdr_reg        <= '0;
            carry_reg      <= '0;
            flush_cnt_reg  <= '0;
            m_tdata_reg    <= '0;
            m_tkeep_reg    <= '0;
            m_tlast_reg    <= 1'b0;
            m_tvalid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= m_tvalid_reg && m_tready && m_tlast_reg;
            if (out_free) begin
                m_tvalid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (hdr_valid && hdr_ready) begin
                        hdr_reg      <= hdr_in_net[79:0];
                        m_tdata_reg  <= beat0_data;
                        m_tkeep_reg  <= 8'hFF;
                        m_tlast_reg  <= 1'b0;
                        m_tvalid_reg <= 1'b1;
                        state_reg    <= HDR0;
                    end
                end
                HDR0: begin
                    if (out_free) begin
                        m_tdata_reg  <= beat1_data;
                        m_tkeep_reg  <= 8'hFF;
                        m_tlast_reg  <= 1'b0;
                        m_tvalid_reg <= 1'b1;
                        carry_reg    <= {hdr_reg[7:0], hdr_reg[15:8]};
                        state_reg    <= HDR1;
                    end
                end
                HDR1, MERGE: begin
                    if (s_tvalid && s_tready) begin
                        m_tdata_reg  <= merge_raw & out_byte_mask;
                        m_tkeep_reg  <= out_mask;
                        m_tvalid_reg <= 1'b1;
                        carry_reg    <= s_tdata[63:48];
                        if (s_tlast && (s_count > 4'd6)) begin
                            m_tlast_reg   <= 1'b0;
                            flush_cnt_reg <= s_count - 4'd6;
                            state_reg     <= FLUSH;
                        end else if (s_tlast) begin
                            m_tlast_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            m_tlast_reg <= 1'b0;
                            state_reg   <= MERGE;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        m_tdata_reg  <= {48'h0, carry_reg} & out_byte_mask;
                        m_tkeep_reg  <= out_mask;
                        m_tlast_reg  <= 1'b1;
                        m_tvalid_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_tdata    = m_tdata_reg;
    assign m_tkeep    = m_tkeep_reg;
    assign m_tlast    = m_tlast_reg;
    assign m_tvalid   = m_tvalid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_eth_hdr_inserter.sv
// Directed bench for eth_hdr_inserter with a byte-stream scoreboard.
`timescale 1ns/1ps
module tb_eth_hdr_inserter;

    typedef struct {
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] tci;
        logic [15:0] et;
        int          len;
        int          off;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_dst_mac;
    logic [47:0] hdr_src_mac;
    logic [15:0] hdr_vlan_tci;
    logic [15:0] hdr_ethertype;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        frame_done;

    frame_t      frames[$];
    logic [7:0]  pay[$];
    logic [72:0] exp_q[$];   // {last, keep, data}
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    eth_hdr_inserter dut (
        .clk           (clk),
        .rst           (rst),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr_dst_mac   (hdr_dst_mac),
        .hdr_src_mac   (hdr_src_mac),
        .hdr_vlan_tci  (hdr_vlan_tci),
        .hdr_ethertype (hdr_ethertype),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .frame_done    (frame_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a frame: payload bytes (pat<0 -> random, else pat+i) and the
    // expected output beats from chunking header+payload into 8-byte beats.
    task automatic add_frame(input logic [47:0] da, input logic [47:0] sa,
                             input logic [15:0] tci, input logic [15:0] et,
                             input int len, input int pat);
        frame_t     f;
        logic [7:0] s[$];
        logic [7:0] b;
        logic [63:0] d;
        logic [7:0]  k;
        int nb;
        f.da = da; f.sa = sa; f.tci = tci; f.et = et; f.len = len; f.off = pay.size();
        for (int i = 0; i < 6; i++) s.push_back(da[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) s.push_back(sa[47 - 8*i -: 8]);
        s.push_back(8'h81); s.push_back(8'h00);
        s.push_back(tci[15:8]); s.push_back(tci[7:0]);
        s.push_back(et[15:8]);  s.push_back(et[7:0]);
        for (int i = 0; i < len; i++) begin
            b = (pat < 0) ? 8'($urandom) : 8'(pat + i);
            pay.push_back(b);
            s.push_back(b);
        end
        nb = (s.size() + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            d = '0; k = '0;
            for (int i = 0; i < 8; i++) begin
                if (bi*8 + i < s.size()) begin
                    d[8*i +: 8] = s[bi*8 + i];
                    k[i] = 1'b1;
                end
            end
            exp_q.push_back({(bi == nb - 1), k, d});
        end
        frames.push_back(f);
    endtask

    task automatic drive_all();
        int n;
        int nbeats;
        for (int fi = 0; fi < frames.size(); fi++) begin
            @(negedge clk);
            s_tvalid = 1'b0; s_tlast = 1'b0;
            hdr_valid = 1'b1;
            hdr_dst_mac = frames[fi].da; hdr_src_mac = frames[fi].sa;
            hdr_vlan_tci = frames[fi].tci; hdr_ethertype = frames[fi].et;
            #1; n = 0;
            while (!hdr_ready && n < 3000) begin @(negedge clk); #1; n++; end
            nbeats = (frames[fi].len + 7) / 8;
            for (int bi = 0; bi < nbeats; bi++) begin
                @(negedge clk);
                hdr_valid = 1'b0;
                s_tvalid = 1'b1; s_tdata = {8{8'hEE}}; s_tkeep = '0;
                for (int i = 0; i < 8; i++) begin
                    if (bi*8 + i < frames[fi].len) begin
                        s_tdata[8*i +: 8] = pay[frames[fi].off + bi*8 + i];
                        s_tkeep[i] = 1'b1;
                    end
                end
                s_tlast = (bi == nbeats - 1);
                #1; n = 0;
                while (!s_tready && n < 3000) begin @(negedge clk); #1; n++; end
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; hdr_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd, input int nframes, input int exp_bytes);
        int nb, got, cyc, gaps, bytes, dones;
        bit hold, started;
        logic [73:0] prev, cur;
        logic [72:0] e;
        nb = exp_q.size(); got = 0; cyc = 0; gaps = 0; bytes = 0; dones = 0;
        hold = 0; started = 0; prev = '0;
        while (got < nb && cyc < 20000) begin
            @(negedge clk);
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1; cyc++;
            if (frame_done) dones++;
            cur = {m_tvalid, m_tlast, m_tkeep, m_tdata};
            if (hold) check("stall_hold", 128'(cur), 128'(prev));
            hold = 0;
            if (m_tvalid) begin
                started = 1;
                if (m_tready) begin
                    e = exp_q.pop_front();
                    check("beat", 128'(cur[72:0]), 128'(e));
                    $display("beat %0d: data=%h keep=%h last=%0b", got, m_tdata, m_tkeep, m_tlast);
                    bytes += $countones(m_tkeep);
                    got++;
                end else begin
                    prev = cur;
                    hold = 1;
                end
            end else if (started && got < nb) begin
                gaps++;
            end
        end
        check("beats_seen", 128'(got), 128'(nb));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); m_tready = 1'b1; #1;
            if (frame_done) dones++;
            check("no_extra_valid", 128'(m_tvalid), 128'(1'b0));
        end
        check("frame_done_count", 128'(dones), 128'(nframes));
        check("byte_total", 128'(bytes), 128'(exp_bytes));
        if (!rnd) check("no_bubble", 128'(gaps), 128'(0));
    endtask

    task automatic run_batch(input bit rnd);
        int nf, eb;
        nf = frames.size(); eb = 0;
        foreach (frames[i]) eb += 18 + frames[i].len;
        fork
            drive_all();
            collect(rnd, nf, eb);
        join
        frames.delete(); pay.delete(); exp_q.delete();
    endtask

    initial begin
        int n, acc;
        rst = 1'b1; hdr_valid = 1'b0; hdr_dst_mac = '0; hdr_src_mac = '0;
        hdr_vlan_tci = '0; hdr_ethertype = '0; s_tdata = '0; s_tkeep = '0;
        s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("rst_m_tdata", 128'(m_tdata), 128'(64'h0));
        check("rst_m_tkeep", 128'(m_tkeep), 128'(8'h0));
        check("rst_m_tlast", 128'(m_tlast), 128'(1'b0));
        check("rst_frame_done", 128'(frame_done), 128'(1'b0));
        check("rst_hdr_ready", 128'(hdr_ready), 128'(1'b0));
        check("rst_s_tready", 128'(s_tready), 128'(1'b0));
        @(negedge clk); rst = 1'b0; #1;
        check("post_rst_hdr_ready", 128'(hdr_ready), 128'(1'b1));
        check("post_rst_s_tready", 128'(s_tready), 128'(1'b0));

        // 1-byte payload: 3 beats, 19 bytes, last keep 0x07
        add_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0064, 16'h0800, 1, 8'hAA);
        run_batch(1'b0);

        // 8-byte payload: full merged beat then 2-byte overflow beat
        add_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0064, 16'h0800, 8, 0);
        run_batch(1'b0);

        // 64-byte payload under random backpressure
        add_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h2123, 16'h86DD, 64, 8'h10);
        run_batch(1'b1);

        // Back-to-back frames with sink always ready
        add_frame(48'h111111111111, 48'h222222222222, 16'h0001, 16'h0800, 1, -1);
        add_frame(48'h333333333333, 48'h444444444444, 16'h0002, 16'h0806, 8, -1);
        add_frame(48'h555555555555, 48'h666666666666, 16'h0003, 16'h88CC, 13, -1);
        add_frame(48'h777777777777, 48'h888888888888, 16'h0FFF, 16'h0800, 6, -1);
        add_frame(48'h999999999999, 48'hAAAAAAAAAAAA, 16'h0004, 16'h0800, 7, -1);
        run_batch(1'b0);

        // Reset in the middle of a 40-byte frame
        m_tready = 1'b1;
        @(negedge clk);
        hdr_valid = 1'b1; hdr_dst_mac = 48'hDEADBEEF0001; hdr_src_mac = 48'hCAFE00000002;
        hdr_vlan_tci = 16'h0005; hdr_ethertype = 16'h0800;
        #1; n = 0;
        while (!hdr_ready && n < 100) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        hdr_valid = 1'b0; s_tvalid = 1'b1; s_tdata = {8{8'h55}}; s_tkeep = 8'hFF; s_tlast = 1'b0;
        acc = 0; n = 0;
        while (acc < 3 && n < 100) begin
            #1; if (s_tready) acc++;
            @(negedge clk); n++;
        end
        check("mid_rst_reached_merge", 128'(acc), 128'(3));
        rst = 1'b1; #1;
        check("mid_rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("mid_rst_s_tready", 128'(s_tready), 128'(1'b0));
        s_tvalid = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0; #1;
        check("mid_rst_hdr_ready", 128'(hdr_ready), 128'(1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("mid_rst_no_valid", 128'(m_tvalid), 128'(1'b0));
            check("mid_rst_no_done", 128'(frame_done), 128'(1'b0));
        end
        add_frame(48'hDEADBEEF0001, 48'hCAFE00000002, 16'h0005, 16'h0800, 40, -1);
        run_batch(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_hdr_inserter.md
ETH_HDR_INSERTER -- requirements
Module: eth_hdr_inserter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, output/payload beat width in bits (only 64 supported).
REQ-002 SHALL have parameter HEADER_BYTES, default 18, emitted header length (only 18 supported: DA 6, SA 6, TPID 2, TCI 2, EtherType 2).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports hdr_valid input 1, hdr_ready output 1: header-field handshake.
REQ-006 SHALL have ports hdr_dst_mac input 48, hdr_src_mac input 48, hdr_vlan_tci input 16, hdr_ethertype input 16: header fields, sampled at hdr handshake.
REQ-007 SHALL have ports s_tdata input 64, s_tkeep input 8, s_tlast input 1, s_tvalid input 1, s_tready output 1: payload stream.
REQ-008 SHALL have ports m_tdata output 64, m_tkeep output 8, m_tlast output 1, m_tvalid output 1, m_tready input 1: framed output stream.
REQ-009 SHALL have port frame_done output 1: single-cycle pulse on acceptance of the m_tlast beat.

Function
REQ-010 Byte n of a beat SHALL occupy tdata[8n+7:8n]; header byte 0 = hdr_dst_mac[47:40]; all fields network (MSB-first) order; TPID constant 0x8100.
REQ-011 tkeep SHALL be contiguous from bit 0; only the tlast beat may be partial; payload SHALL carry at least 1 byte (violation undefined).
REQ-012 States: IDLE, HDR0, HDR1, MERGE, FLUSH.
REQ-013 IDLE: hdr_ready=1; on hdr_valid SHALL latch all fields and go to HDR0; s_tready=0.
REQ-014 HDR0 / HDR1 SHALL present header bytes 0-7 / 8-15 with m_tkeep=0xFF, m_tlast=0; advance on m_tvalid&&m_tready; HDR1 preloads carry = header bytes 16-17 and enters MERGE.
REQ-015 MERGE: s_tready = (!m_tvalid || m_tready); per accepted input beat output = {carry[2 bytes], s_tdata bytes 0-5}, new carry = s_tdata bytes 6-7.
REQ-016 MERGE, s_tlast beat with k valid bytes: k<=6 -> output m_tkeep has 2+k ones, m_tlast=1, go IDLE; k>6 -> output full 0xFF beat m_tlast=0, go FLUSH.
REQ-017 FLUSH: s_tready=0; output carry bytes 0..k-7 with m_tkeep (k-6) ones, m_tlast=1; go IDLE on acceptance.
REQ-018 Outputs SHALL be registered; m_tdata/m_tkeep/m_tlast SHALL hold stable while m_tvalid && !m_tready.
REQ-019 Latency: first header beat valid 1 cycle after hdr handshake; no bubbles while s_tvalid and m_tready held high.
REQ-020 hdr_ready SHALL be 0 outside IDLE; next frame's hdr handshake may occur the cycle the tlast beat is accepted (back-to-back frames, no idle cycle).
REQ-021 frame_done SHALL assert exactly once per frame, the cycle after the tlast beat handshake.
REQ-022 Output byte total per frame SHALL equal 18 + payload bytes; unused m_tdata bytes SHALL be driven 0.

Reset
REQ-023 rst SHALL asynchronously force state=IDLE, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, frame_done=0, carry and latched fields=0.
REQ-024 hdr_ready SHALL be 0 while rst asserted and 1 in the first cycle after deassertion; s_tready 0 during and after reset until MERGE.
REQ-025 Reset mid-frame SHALL discard the frame; no tlast is emitted for it.

Structure
REQ-026 Shared package eth_pkg SHALL hold TPID_VLAN=16'h8100, HEADER_BYTES=18, BYTES_PER_BEAT, and the state enum type.
REQ-027 One sub-module natural: keep_count (tkeep -> valid-byte count and count -> tkeep mask), reused by the parser side.

Verification
REQ-028 DA=01:02:03:04:05:06, SA=0A:0B:0C:0D:0E:0F, TCI=0x0064, type=0x0800, 1-byte payload 0xAA -> 3 beats, last m_tdata bytes {08,00,AA}, m_tkeep=0x07, total 19 bytes.
REQ-029 Payload 8 bytes 00..07 single beat -> beat2 = {08,00,00..05} keep 0xFF, FLUSH beat {06,07} keep 0x03 tlast.
REQ-030 Payload 64 bytes, random m_tready 50% -> output stable under stall, 82 bytes, 11 beats, last keep 0x03, one frame_done.
REQ-031 Two frames back-to-back, s_tvalid and m_tready held 1 -> no idle cycle between frames, header of frame 2 immediately after tlast of frame 1.
REQ-032 rst pulse during MERGE of 40-byte frame -> m_tvalid=0 same cycle, no tlast/frame_done; next frame correct.
